// File: rtl/delay_measure_ctrl.sv
// Delay-line measurement sequencer: fires PULSE_WIDTH-cycle shots, times each echo,
// and reports the truncated average over 2^NUM_AVG_LOG2 shots (or a timeout error).
module delay_measure_ctrl #(
  parameter int unsigned PULSE_WIDTH  = 4,
  parameter int unsigned MAX_WAIT     = 1024,
  parameter int unsigned NUM_AVG_LOG2 = 3,
  parameter int unsigned GAP          = 32,
  localparam int unsigned CNT_W       = $clog2(MAX_WAIT),
  localparam int unsigned ACC_W       = CNT_W + NUM_AVG_LOG2
) (
  input  logic             clk,
  input  logic             n_reset,
  input  logic             start,
  input  logic             edge_in,
  output logic             tx_out,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] result,
  output logic             timeout_err
);

  localparam int unsigned SHOT_W    = (NUM_AVG_LOG2 > 0) ? NUM_AVG_LOG2 : 1;
  localparam int unsigned NUM_SHOTS = 1 << NUM_AVG_LOG2;
  localparam int unsigned GAP_W     = $clog2(GAP + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FIRE,
    S_LISTEN,
    S_GAP,
    S_FINISH
  } state_e;

  state_e             state_q;
  logic [CNT_W-1:0]   t_q;
  logic [GAP_W-1:0]   gap_q;
  logic [SHOT_W-1:0]  shot_q;
  logic [ACC_W-1:0]   acc_q;
  logic [ACC_W-1:0]   acc_d;
  logic               last_shot;
  logic               tx_q;
  logic               busy_q;
  logic               done_q;
  logic [CNT_W-1:0]   result_q;
  logic               timeout_err_q;

  // Running sum including the sample that would be taken this cycle
  assign acc_d     = acc_q + ACC_W'(t_q);
  assign last_shot = (shot_q == SHOT_W'(NUM_SHOTS - 1));

  always_ff @(posedge clk) begin
    if (!n_reset) begin
      state_q       <= S_IDLE;
      t_q           <= '0;
      gap_q         <= '0;
      shot_q        <= '0;
      acc_q         <= '0;
      tx_q          <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      result_q      <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q <= S_FIRE;
            t_q     <= '0;
            shot_q  <= '0;
            acc_q   <= '0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b1;
          end
        end

        S_FIRE: begin
          t_q <= t_q + CNT_W'(1);
          if (t_q == CNT_W'(PULSE_WIDTH - 1)) begin
            state_q <= S_LISTEN;
            tx_q    <= 1'b0;
          end
        end

        // An echo in the final listen cycle takes priority over the timeout
        S_LISTEN: begin
          if (edge_in) begin
            acc_q <= acc_d;
            if (last_shot) begin
              state_q       <= S_FINISH;
              done_q        <= 1'b1;
              result_q      <= CNT_W'(acc_d >> NUM_AVG_LOG2);
              timeout_err_q <= 1'b0;
            end else begin
              state_q <= S_GAP;
              gap_q   <= '0;
              shot_q  <= shot_q + SHOT_W'(1);
            end
          end else if (t_q == CNT_W'(MAX_WAIT - 1)) begin
            state_q       <= S_FINISH;
            done_q        <= 1'b1;
            result_q      <= '0;
            timeout_err_q <= 1'b1;
          end else begin
            t_q <= t_q + CNT_W'(1);
          end
        end

        S_GAP: begin
          if (gap_q == GAP_W'(GAP - 1)) begin
            state_q <= S_FIRE;
            t_q     <= '0;
            tx_q    <= 1'b1;
          end else begin
            gap_q <= gap_q + GAP_W'(1);
          end
        end

        S_FINISH: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end

        default: begin
          state_q <= S_IDLE;
          tx_q    <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign tx_out      = tx_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign result      = result_q;
  assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_delay_measure_ctrl.sv
// Self-checking bench for delay_measure_ctrl: echo model driven from a vector table,
// expected results queued at start and compared when done strobes.
module tb_delay_measure_ctrl;

  localparam int unsigned PW   = 4;
  localparam int unsigned MW   = 1024;
  localparam int unsigned NL   = 3;
  localparam int unsigned GP   = 32;
  localparam int unsigned CW   = $clog2(MW);

  logic          clk = 1'b0;
  logic          n_reset;
  logic          start;
  logic          edge_in;
  logic          tx_out;
  logic          busy;
  logic          done;
  logic [CW-1:0] result;
  logic          timeout_err;

  always #5 clk = ~clk;

  delay_measure_ctrl #(
    .PULSE_WIDTH (PW),
    .MAX_WAIT    (MW),
    .NUM_AVG_LOG2(NL),
    .GAP         (GP)
  ) dut (
    .clk        (clk),
    .n_reset    (n_reset),
    .start      (start),
    .edge_in    (edge_in),
    .tx_out     (tx_out),
    .busy       (busy),
    .done       (done),
    .result     (result),
    .timeout_err(timeout_err)
  );

  typedef struct {
    int d[8];
    int exp_result;
    int exp_err;
    int exp_lat;
    int exp_pulses;
    bit noise;
  } vec_t;

  typedef struct {
    int res;
    int err;
    int lat;
    int pulses;
  } exp_t;

  exp_t sb[$];
  vec_t vt[7];
  int   errors = 0;
  int   checks = 0;

  function automatic void check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endfunction

  // One measurement: start at the current negedge, model echoes, compare at done
  task automatic run(input vec_t v, input string tag);
    int   n = 0;
    int   shot = -1;
    int   t = 0;
    int   pulses = 0;
    int   plen = 0;
    bit   active = 1'b0;
    bit   echoed = 1'b0;
    bit   prev_tx = 1'b0;
    bit   got = 1'b0;
    exp_t e;
    check({tag, "/idle_busy"}, int'(busy), 0);
    start = 1'b1;
    sb.push_back('{v.exp_result, v.exp_err, v.exp_lat, v.exp_pulses});
    while (n < 4000 && !got) begin
      @(negedge clk);
      n++;
      start = v.noise && (n == 10 || n == 300);
      if (tx_out && !prev_tx) begin
        shot++;
        t = 0;
        active = 1'b1;
        echoed = 1'b0;
        plen = 0;
        pulses++;
      end else if (active) begin
        t++;
      end
      if (tx_out) plen++;
      if (!tx_out && prev_tx) check({tag, "/pulse_width"}, plen, PW);
      edge_in = 1'b0;
      if (active && !echoed && shot < 8 && v.d[shot] >= 0 && t == v.d[shot]) begin
        edge_in = 1'b1;
        echoed = 1'b1;
      end else if (v.noise && active && shot < 8 &&
                   (t == 2 || (echoed && t == v.d[shot] + 10))) begin
        edge_in = 1'b1;
      end
      prev_tx = tx_out;
      if (done) got = 1'b1;
    end
    edge_in = 1'b0;
    start = 1'b0;
    check({tag, "/done_seen"}, int'(got), 1);
    if (got && sb.size() > 0) begin
      e = sb.pop_front();
      check({tag, "/result"}, int'(result), e.res);
      check({tag, "/timeout_err"}, int'(timeout_err), e.err);
      check({tag, "/latency"}, n, e.lat);
      check({tag, "/pulses"}, pulses, e.pulses);
      check({tag, "/busy_in_finish"}, int'(busy), 1);
    end
    @(negedge clk);
    check({tag, "/done_one_cycle"}, int'(done), 0);
    check({tag, "/busy_falls"}, int'(busy), 0);
  endtask

  initial begin
    int n;
    int done_cnt;

    for (int i = 0; i < 8; i++) begin
      vt[0].d[i] = 100;
      vt[1].d[i] = 100 + i;
      vt[2].d[i] = (i == 7) ? 6 : 5;
      vt[3].d[i] = (i == 2) ? -1 : 100;
      vt[4].d[i] = (i == 2) ? 1023 : 100;
      vt[5].d[i] = 100;
      vt[6].d[i] = 50;
    end
    vt[0].exp_result = 100; vt[0].exp_err = 0; vt[0].exp_lat = 1033; vt[0].exp_pulses = 8; vt[0].noise = 1'b0;
    vt[1].exp_result = 103; vt[1].exp_err = 0; vt[1].exp_lat = 1061; vt[1].exp_pulses = 8; vt[1].noise = 1'b0;
    vt[2].exp_result = 5;   vt[2].exp_err = 0; vt[2].exp_lat = 274;  vt[2].exp_pulses = 8; vt[2].noise = 1'b0;
    vt[3].exp_result = 0;   vt[3].exp_err = 1; vt[3].exp_lat = 1291; vt[3].exp_pulses = 3; vt[3].noise = 1'b0;
    vt[4].exp_result = 215; vt[4].exp_err = 0; vt[4].exp_lat = 1956; vt[4].exp_pulses = 8; vt[4].noise = 1'b0;
    vt[5].exp_result = 100; vt[5].exp_err = 0; vt[5].exp_lat = 1033; vt[5].exp_pulses = 8; vt[5].noise = 1'b1;
    vt[6].exp_result = 50;  vt[6].exp_err = 0; vt[6].exp_lat = 633;  vt[6].exp_pulses = 8; vt[6].noise = 1'b0;

    // Reset held with start high
    n_reset = 1'b0;
    start   = 1'b1;
    edge_in = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset/tx_out", int'(tx_out), 0);
    check("reset/busy", int'(busy), 0);
    check("reset/done", int'(done), 0);
    check("reset/result", int'(result), 0);
    check("reset/timeout_err", int'(timeout_err), 0);
    start   = 1'b0;
    n_reset = 1'b1;
    @(negedge clk);
    check("post_reset/busy", int'(busy), 0);

    // Back-to-back runs: each starts in the first IDLE cycle after the previous done
    for (int i = 0; i < 6; i++) run(vt[i], $sformatf("vec%0d", i));

    // A start pulsed while busy must not have been queued
    repeat (3) @(negedge clk);
    check("no_queue/busy", int'(busy), 0);
    check("no_queue/tx_out", int'(tx_out), 0);

    // Reset during LISTEN of the second shot
    start = 1'b1;
    n = 0;
    done_cnt = 0;
    while (n < 150) begin
      @(negedge clk);
      n++;
      start = 1'b0;
      edge_in = (n == 101);
      if (done) done_cnt++;
    end
    edge_in = 1'b0;
    n_reset = 1'b0;
    @(negedge clk);
    check("midreset/tx_out", int'(tx_out), 0);
    check("midreset/busy", int'(busy), 0);
    check("midreset/result", int'(result), 0);
    n_reset = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (done) done_cnt++;
    end
    check("midreset/no_done", done_cnt, 0);
    run(vt[6], "fresh50");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
